// File: rtl/red_pitaya_sort_scheduler_if.sv
// Request, configuration and status bundle of red_pitaya_sort_scheduler.
// With SORT_SCHED_LATE_DISCARD_EN defined it also carries cfg_max_late_i and skip_cnt_o.
interface red_pitaya_sort_scheduler_if #(
   parameter int QSZ = 3,
   parameter int TW  = 32
);
   logic          sort_req_i;
   logic          enable_i;
   logic          flush_i;
   logic          clr_cnt_i;
   logic [TW-1:0] cfg_delay_i;
   logic [TW-1:0] cfg_duration_i;
   logic [TW-1:0] cfg_gap_i;
`ifdef SORT_SCHED_LATE_DISCARD_EN
   logic [TW-1:0] cfg_max_late_i;
   logic [TW-1:0] skip_cnt_o;
`endif
   logic          sort_trig_o;
   logic          busy_o;
   logic [QSZ:0]  pending_o;
   logic [TW-1:0] fired_cnt_o;
   logic [TW-1:0] drop_cnt_o;
   logic [TW-1:0] late_cnt_o;

   modport master (
      output sort_req_i, enable_i, flush_i, clr_cnt_i,
      output cfg_delay_i, cfg_duration_i, cfg_gap_i,
`ifdef SORT_SCHED_LATE_DISCARD_EN
      output cfg_max_late_i,
      input  skip_cnt_o,
`endif
      input  sort_trig_o, busy_o, pending_o, fired_cnt_o, drop_cnt_o, late_cnt_o
   );

   modport slave (
      input  sort_req_i, enable_i, flush_i, clr_cnt_i,
      input  cfg_delay_i, cfg_duration_i, cfg_gap_i,
`ifdef SORT_SCHED_LATE_DISCARD_EN
      input  cfg_max_late_i,
      output skip_cnt_o,
`endif
      output sort_trig_o, busy_o, pending_o, fired_cnt_o, drop_cnt_o, late_cnt_o
   );
endinterface

// File: rtl/red_pitaya_sort_scheduler.sv
// Timestamps sort requests, queues them and fires one fixed-width trigger pulse per entry at its due time.
// Optional SORT_SCHED_LATE_DISCARD_EN: heads later than cfg_max_late_i are dropped without a pulse.
module red_pitaya_sort_scheduler #(
   parameter int QSZ = 3,
   parameter int TW  = 32
) (
   input  logic                        adc_clk_i,
   input  logic                        adc_rstn_i,
   red_pitaya_sort_scheduler_if.slave  bus
);
   localparam int             DEPTH    = 1 << QSZ;
   localparam logic [QSZ:0]   FULL_CNT = (QSZ+1)'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  now_q, now_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic [TW-1:0]  gap_q, gap_d;
   logic [QSZ-1:0] wr_ptr_q, wr_ptr_d;
   logic [QSZ-1:0] rd_ptr_q, rd_ptr_d;
   logic [QSZ:0]   cnt_q, cnt_d;
   logic           trig_q, trig_d;
   logic [TW-1:0]  fired_q, fired_d;
   logic [TW-1:0]  drop_q, drop_d;
   logic [TW-1:0]  late_q, late_d;
   logic [TW-1:0]  mem_q [DEPTH];

   logic [TW-1:0]  head_age;
   logic           head_due, head_late;
   logic           push_req, push_ok, drop, fire, skip, pop;

   // Age of the head read as signed: non-negative means due, even across time-base wrap.
   assign head_age  = now_q - mem_q[rd_ptr_q];
   assign head_due  = (cnt_q != '0) && !head_age[TW-1];
   assign head_late = head_due && (head_age != '0);
   assign push_req  = bus.sort_req_i && bus.enable_i && !bus.flush_i;

`ifdef SORT_SCHED_LATE_DISCARD_EN
   logic [TW-1:0] skip_q, skip_d;
   assign skip = (state_q == ST_IDLE) && head_due && !bus.flush_i && (head_age > bus.cfg_max_late_i);
`else
   assign skip = 1'b0;
`endif

   assign fire    = (state_q == ST_IDLE) && head_due && !bus.flush_i && !skip;
   assign pop     = fire || skip;
   assign push_ok = push_req && ((cnt_q != FULL_CNT) || pop);
   assign drop    = push_req && !push_ok;

   function automatic logic [TW-1:0] cnt_next(input logic [TW-1:0] c, input logic inc, input logic clr);
      if (clr) return '0;
      if (inc && (c != '1)) return c + TW'(1);
      return c;
   endfunction

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
      state_d = state_q;
      tmr_d   = tmr_q;
      gap_d   = gap_q;
      unique case (state_q)
         ST_IDLE: begin
            if (fire) begin
               state_d = ST_PULSE;
               tmr_d   = (bus.cfg_duration_i == '0) ? '0 : bus.cfg_duration_i - TW'(1);
               gap_d   = bus.cfg_gap_i;
            end
         end
         ST_PULSE: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - TW'(1);
            end else if (gap_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GAP;
               tmr_d   = gap_q - TW'(1);
            end
         end
         ST_GAP: begin
            if (tmr_q != '0) tmr_d = tmr_q - TW'(1);
            else             state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.flush_i) state_d = ST_IDLE;
      trig_d = (state_d == ST_PULSE);
   end

   always_comb begin
      now_d    = now_q + TW'(1);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (bus.flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + QSZ'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + QSZ'(1);
         cnt_d = cnt_q + (QSZ+1)'(push_ok) - (QSZ+1)'(pop);
      end
      fired_d = cnt_next(fired_q, fire, bus.clr_cnt_i);
      late_d  = cnt_next(late_q, fire && head_late, bus.clr_cnt_i);
      drop_d  = cnt_next(drop_q, drop, bus.clr_cnt_i);
`ifdef SORT_SCHED_LATE_DISCARD_EN
      skip_d  = cnt_next(skip_q, skip, bus.clr_cnt_i);
`endif
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         state_q  <= ST_IDLE;
         now_q    <= '0;
         tmr_q    <= '0;
         gap_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         trig_q   <= 1'b0;
         fired_q  <= '0;
         drop_q   <= '0;
         late_q   <= '0;
      end else begin
         state_q  <= state_d;
         now_q    <= now_d;
         tmr_q    <= tmr_d;
         gap_q    <= gap_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         trig_q   <= trig_d;
         fired_q  <= fired_d;
         drop_q   <= drop_d;
         late_q   <= late_d;
      end
   end

`ifdef SORT_SCHED_LATE_DISCARD_EN
   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) skip_q <= '0;
      else             skip_q <= skip_d;
   end
   assign bus.skip_cnt_o = skip_q;
`endif

   // NOTE: queue storage is not reset; cnt_q and the pointers alone decide which entries are valid.
   always_ff @(posedge adc_clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= now_q + bus.cfg_delay_i;
   end

   assign bus.sort_trig_o = trig_q;
   assign bus.busy_o      = (state_q != ST_IDLE);
   assign bus.pending_o   = cnt_q;
   assign bus.fired_cnt_o = fired_q;
   assign bus.drop_cnt_o  = drop_q;
   assign bus.late_cnt_o  = late_q;
endmodule

// File: tb/tb_red_pitaya_sort_scheduler.sv
// Bench for red_pitaya_sort_scheduler: directed table, corner sequences and random traffic against an event-level model.
// A TW=8 copy shares the stimulus so wrap-safe due tests are exercised within a short run.
module tb_red_pitaya_sort_scheduler;
   localparam int QSZ   = 3;
   localparam int TW    = 32;
   localparam int DEPTH = 1 << QSZ;

   logic clk;
   logic rst_n = 1'b1;

   red_pitaya_sort_scheduler_if #(.QSZ(QSZ), .TW(TW)) bus ();
   red_pitaya_sort_scheduler_if #(.QSZ(QSZ), .TW(8))  bus8 ();

   red_pitaya_sort_scheduler #(.QSZ(QSZ), .TW(TW)) dut  (.adc_clk_i(clk), .adc_rstn_i(rst_n), .bus(bus));
   red_pitaya_sort_scheduler #(.QSZ(QSZ), .TW(8))  dut8 (.adc_clk_i(clk), .adc_rstn_i(rst_n), .bus(bus8));

   assign bus8.sort_req_i     = bus.sort_req_i;
   assign bus8.enable_i       = bus.enable_i;
   assign bus8.flush_i        = bus.flush_i;
   assign bus8.clr_cnt_i      = bus.clr_cnt_i;
   assign bus8.cfg_delay_i    = bus.cfg_delay_i[7:0];
   assign bus8.cfg_duration_i = bus.cfg_duration_i[7:0];
   assign bus8.cfg_gap_i      = bus.cfg_gap_i[7:0];
`ifdef SORT_SCHED_LATE_DISCARD_EN
   assign bus8.cfg_max_late_i = bus.cfg_max_late_i[7:0];
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: absolute cycle numbers, a queue of due times and the interval of the current pulse.
   longint m_k, m_idle_from, m_pstart, m_pend;
   longint m_q[$];
   longint m_fired, m_drop, m_late, m_skip;

   int   n_checks = 0;
   int   n_pass   = 0;
   bit   cmp8     = 1'b0;
   logic last_trig, last_trig8, prev_trig;
   int   rises;

   typedef struct {
      int d;
      int dur;
      int gap;
      int lat;
      int width;
      int late;
   } vec_t;
   vec_t tbl [5];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (model cycle %0d)", name, act, exp, m_k);
   endtask

   task automatic model_reset();
      m_k = 0; m_idle_from = 0; m_pstart = 1; m_pend = 0;
      m_q.delete();
      m_fired = 0; m_drop = 0; m_late = 0; m_skip = 0;
   endtask

   task automatic model_step(input bit req, input bit en, input bit fl, input bit clr);
      longint age, dur, gap;
      bit f_inc, l_inc, d_inc, s_inc;
      f_inc = 0; l_inc = 0; d_inc = 0; s_inc = 0;
      dur = (bus.cfg_duration_i == 0) ? 1 : longint'(bus.cfg_duration_i);
      gap = longint'(bus.cfg_gap_i);
      if (fl) begin
         m_q.delete();
         if (m_idle_from > m_k + 1) m_idle_from = m_k + 1;
         if (m_pend > m_k) m_pend = m_k;
      end else begin
         if (m_k >= m_idle_from && m_q.size() > 0 && m_k >= m_q[0]) begin
            age = m_k - m_q[0];
            void'(m_q.pop_front());
`ifdef SORT_SCHED_LATE_DISCARD_EN
            if (age > longint'(bus.cfg_max_late_i)) s_inc = 1;
            else
`endif
            begin
               f_inc = 1;
               l_inc = (age > 0);
               m_pstart = m_k + 1;
               m_pend = m_k + dur;
               m_idle_from = m_pend + gap + 1;
            end
         end
         if (req && en) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_k + longint'(bus.cfg_delay_i));
            else d_inc = 1;
         end
      end
      if (clr) begin
         m_fired = 0; m_late = 0; m_drop = 0; m_skip = 0;
      end else begin
         m_fired += f_inc; m_late += l_inc; m_drop += d_inc; m_skip += s_inc;
      end
      m_k++;
   endtask

   // One clock cycle: apply inputs, compare every output at the falling edge, advance the model.
   task automatic tick(input bit req, input bit en, input bit fl, input bit clr);
      bus.sort_req_i = req; bus.enable_i = en; bus.flush_i = fl; bus.clr_cnt_i = clr;
      @(negedge clk);
      last_trig  = bus.sort_trig_o;
      last_trig8 = bus8.sort_trig_o;
      if (last_trig && !prev_trig) rises++;
      prev_trig = last_trig;
      check("trig", bus.sort_trig_o, (m_k >= m_pstart && m_k <= m_pend));
      check("busy", bus.busy_o, (m_k < m_idle_from));
      check("pending", bus.pending_o, m_q.size());
      check("fired", bus.fired_cnt_o, m_fired);
      check("drop", bus.drop_cnt_o, m_drop);
      check("late", bus.late_cnt_o, m_late);
`ifdef SORT_SCHED_LATE_DISCARD_EN
      check("skip", bus.skip_cnt_o, m_skip);
`endif
      if (cmp8) begin
         check("trig8", bus8.sort_trig_o, (m_k >= m_pstart && m_k <= m_pend));
         check("busy8", bus8.busy_o, (m_k < m_idle_from));
         check("pending8", bus8.pending_o, m_q.size());
      end
      model_step(req, en, fl, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.sort_req_i = 0; bus.enable_i = 0; bus.flush_i = 0; bus.clr_cnt_i = 0;
      rst_n = 1'b0;
      #2;
      check("rst_trig", bus.sort_trig_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_pending", bus.pending_o, 0);
      check("rst_fired", bus.fired_cnt_o, 0);
      check("rst_drop", bus.drop_cnt_o, 0);
      check("rst_late", bus.late_cnt_o, 0);
`ifdef SORT_SCHED_LATE_DISCARD_EN
      check("rst_skip", bus.skip_cnt_o, 0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      prev_trig = 1'b0;
      rises = 0;
   endtask

   task automatic set_cfg(input int d, input int dur, input int gap);
      bus.cfg_delay_i = d; bus.cfg_duration_i = dur; bus.cfg_gap_i = gap;
`ifdef SORT_SCHED_LATE_DISCARD_EN
      bus.cfg_max_late_i = '1;
`endif
   endtask

   task automatic wait_rise(input int limit, output int n);
      n = 0;
      do begin
         tick(0, 1, 0, 0);
         n++;
      end while (!last_trig && n < limit);
   endtask

   task automatic measure_width(input int limit, output int w);
      w = 1;
      for (int i = 0; i < limit; i++) begin
         tick(0, 1, 0, 0);
         if (!last_trig) break;
         w++;
      end
   endtask

   initial begin
      int n, w;
      set_cfg(0, 0, 0);

      // Single-request vectors: latency from request cycle to first high cycle, pulse width, late flag.
      tbl[0] = '{100, 10, 5, 101, 10, 0};
      tbl[1] = '{0,   3,  0, 2,   3,  1};
      tbl[2] = '{1,   0,  2, 2,   1,  0};
      tbl[3] = '{7,   2,  0, 8,   2,  0};
      tbl[4] = '{30,  5,  3, 31,  5,  0};
      for (int i = 0; i < 5; i++) begin
         do_reset();
         set_cfg(tbl[i].d, tbl[i].dur, tbl[i].gap);
         repeat (20) tick(0, 1, 0, 0);
         tick(1, 1, 0, 0);
         wait_rise(1000, n);
         check("tbl_latency", n, tbl[i].lat);
         measure_width(1000, w);
         check("tbl_width", w, tbl[i].width);
         repeat (tbl[i].gap + 5) tick(0, 1, 0, 0);
         check("tbl_fired", bus.fired_cnt_o, 1);
         check("tbl_late", bus.late_cnt_o, tbl[i].late);
         check("tbl_pending", bus.pending_o, 0);
      end

      // Burst of eight back-to-back requests.
      do_reset();
      set_cfg(50, 4, 0);
      repeat (8) tick(1, 1, 0, 0);
      repeat (120) tick(0, 1, 0, 0);
      check("burst_pulses", rises, 8);
      check("burst_fired", bus.fired_cnt_o, 8);
      check("burst_late", bus.late_cnt_o, 7);
      check("burst_drop", bus.drop_cnt_o, 0);

      // Overflow: ten requests long before the first is due.
      do_reset();
      set_cfg(1000, 2, 1);
      repeat (10) tick(1, 1, 0, 0);
      check("ovf_pending", bus.pending_o, 8);
      check("ovf_drop", bus.drop_cnt_o, 2);
      repeat (1060) tick(0, 1, 0, 0);
      check("ovf_pulses", rises, 8);
      check("ovf_fired", bus.fired_cnt_o, 8);

      // Flush three cycles into a ten-cycle pulse with four entries pending.
      do_reset();
      set_cfg(5, 10, 2);
      repeat (5) tick(1, 1, 0, 0);
      wait_rise(100, n);
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      check("flush_pending_before", bus.pending_o, 4);
      tick(0, 1, 1, 0);
      tick(0, 1, 0, 0);
      check("flush_trig_after", last_trig, 0);
      check("flush_pending_after", bus.pending_o, 0);
      rises = 0;
      repeat (60) tick(0, 1, 0, 0);
      check("flush_no_more_pulses", rises, 0);
      check("flush_fired", bus.fired_cnt_o, 1);

      // Asynchronous reset in the middle of a pulse.
      set_cfg(3, 10, 0);
      tick(1, 1, 0, 0);
      wait_rise(100, n);
      tick(0, 1, 0, 0);
      check("arst_trig_before", last_trig, 1);
      do_reset();

      // Wrap: the TW=8 copy sees its time base roll over between push and due.
      cmp8 = 1'b1;
      do_reset();
      set_cfg(50, 3, 0);
      repeat (230) tick(0, 1, 0, 0);
      tick(1, 1, 0, 0);
      wait_rise(200, n);
      check("wrap_latency", n, 51);
      check("wrap_trig8", last_trig8, 1);
      repeat (10) tick(0, 1, 0, 0);
      check("wrap_fired8", bus8.fired_cnt_o, 1);
      check("wrap_late8", bus8.late_cnt_o, 0);
      cmp8 = 1'b0;

`ifdef SORT_SCHED_LATE_DISCARD_EN
      // Late discard: the second request is stale once the long first pulse ends.
      do_reset();
      set_cfg(10, 100, 0);
      bus.cfg_max_late_i = 20;
      tick(1, 1, 0, 0);
      repeat (9) tick(0, 1, 0, 0);
      tick(1, 1, 0, 0);
      repeat (150) tick(0, 1, 0, 0);
      check("discard_skip", bus.skip_cnt_o, 1);
      check("discard_fired", bus.fired_cnt_o, 1);
      check("discard_pulses", rises, 1);
`endif

      // Random traffic, both widths compared against the model every cycle.
      cmp8 = 1'b1;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            set_cfg($urandom_range(30, 0), $urandom_range(6, 0), $urandom_range(4, 0));
`ifdef SORT_SCHED_LATE_DISCARD_EN
            bus.cfg_max_late_i = $urandom_range(40, 0);
`endif
         end
         tick($urandom_range(3, 0) == 0, $urandom_range(7, 0) != 0,
              $urandom_range(149, 0) == 0, $urandom_range(99, 0) == 0);
      end
      cmp8 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
